// File: rtl/phy_mdio_init_sequencer_pkg.sv
// phy_init_pkg: states, MDIO frame constants and the PHY write table for the init sequencer
package phy_init_pkg;
  typedef enum logic [2:0] {HOLD, SETTLE, FRAME, GAP, DONE} state_t;
  localparam logic [1:0] ST = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] TA = 2'b10;
  localparam int PREAMBLE_BITS = 32;
  localparam int FRAME_BITS = 64;
  localparam int NUM_WRITES = 4;
  localparam logic [NUM_WRITES-1:0][20:0] WRITE_TABLE = {
    {5'h00, 16'h1340},
    {5'h09, 16'h0200},
    {5'h04, 16'h01E1},
    {5'h00, 16'h8000}
  };
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [4:0] addr, input logic [20:0] entry);
    return {{PREAMBLE_BITS{1'b1}}, ST, OP_WRITE, addr, entry[20:16], TA, entry[15:0]};
  endfunction
endpackage

// File: rtl/mdio_write_shifter.sv
// mdio_write_shifter: shifts one 64-bit MDIO frame MSB-first on registered mdc/mdio, pulses done at the end
module mdio_write_shifter
  import phy_init_pkg::*;
#(
  parameter int unsigned CLK_DIV = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  mdc,
  output logic                  mdio,
  output logic                  done
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(FRAME_BITS);
  logic [FRAME_BITS-2:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic mdc_q, mdc_d, mdio_q, mdio_d, busy_q, busy_d;
  logic half_end, last;
  assign half_end = busy_q && div_q == DW'(CLK_DIV - 1);
  assign last = bit_q == BW'(FRAME_BITS - 1);
  assign done = half_end && mdc_q && last;
  assign mdc = mdc_q;
  assign mdio = mdio_q;
  always_comb begin
    sh_d = sh_q;
    bit_d = bit_q;
    div_d = busy_q ? (half_end ? '0 : div_q + 1'b1) : '0;
    mdc_d = mdc_q;
    mdio_d = mdio_q;
    busy_d = busy_q;
    if (start) begin
      sh_d = frame[FRAME_BITS-2:0];
      bit_d = '0;
      div_d = '0;
      mdc_d = 1'b0;
      mdio_d = frame[FRAME_BITS-1];
      busy_d = 1'b1;
    end else if (half_end) begin
      mdc_d = !mdc_q;
      if (mdc_q) begin
        bit_d = last ? '0 : bit_q + 1'b1;
        sh_d = {sh_q[FRAME_BITS-3:0], 1'b0};
        mdio_d = last ? 1'b1 : sh_q[FRAME_BITS-2];
        busy_d = !last;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_q <= '0;
      bit_q <= '0;
      div_q <= '0;
      mdc_q <= 1'b0;
      mdio_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      bit_q <= bit_d;
      div_q <= div_d;
      mdc_q <= mdc_d;
      mdio_q <= mdio_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/phy_mdio_init_sequencer.sv
// phy_mdio_init_sequencer: PHY reset pulse, settle wait, then fixed Clause-22 MDIO writes; raises phy_init_done
module phy_mdio_init_sequencer
  import phy_init_pkg::*;
#(
  parameter int unsigned CLK_DIV = 32,
  parameter int unsigned RESET_CYCLES = 1250000,
  parameter int unsigned POST_RESET_CYCLES = 6250000,
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter int unsigned GAP_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  output logic phy_resetn,
  output logic mdio_scl,
  output logic mdio_sda,
  output logic phy_init_done
);
  localparam int unsigned MAXC = RESET_CYCLES > POST_RESET_CYCLES ?
    (RESET_CYCLES > GAP_CYCLES ? RESET_CYCLES : GAP_CYCLES) :
    (POST_RESET_CYCLES > GAP_CYCLES ? POST_RESET_CYCLES : GAP_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(NUM_WRITES);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic rn_q, rn_d, done_q, done_d;
  logic start, sh_done;
  logic [FRAME_BITS-1:0] frame;
  assign frame = build_frame(PHY_ADDR, WRITE_TABLE[idx_d]);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    rn_d = rn_q;
    done_d = done_q;
    start = 1'b0;
    case (state_q)
      HOLD: begin
        rn_d = 1'b0;
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          state_d = SETTLE;
          cnt_d = '0;
          rn_d = 1'b1;
        end
      end
      SETTLE: if (cnt_q == CW'(POST_RESET_CYCLES - 1)) begin
        state_d = FRAME;
        cnt_d = '0;
        idx_d = '0;
        start = 1'b1;
      end
      FRAME: begin
        cnt_d = '0;
        state_d = sh_done ? GAP : FRAME;
      end
      GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) begin
        cnt_d = '0;
        if (idx_q == IW'(NUM_WRITES - 1)) begin
          state_d = DONE;
          done_d = 1'b1;
        end else begin
          state_d = FRAME;
          idx_d = idx_q + 1'b1;
          start = 1'b1;
        end
      end
      DONE: cnt_d = cnt_q;
      default: state_d = HOLD;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q <= '0;
      idx_q <= '0;
      rn_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      rn_q <= rn_d;
      done_q <= done_d;
    end
  end
  mdio_write_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clock(clock),
    .reset(reset),
    .start(start),
    .frame(frame),
    .mdc(mdio_scl),
    .mdio(mdio_sda),
    .done(sh_done)
  );
  assign phy_resetn = rn_q;
  assign phy_init_done = done_q;
endmodule

// File: tb/tb_phy_mdio_init_sequencer.sv
// tb_phy_mdio_init_sequencer: cycle model plus MDIO frame decoder checking the init sequencer
module tb_phy_mdio_init_sequencer;
  localparam int R = 10;
  localparam int P = 20;
  localparam int D = 2;
  localparam int G = 4;
  localparam int FT = 128 * D;
  localparam int SLOT = FT + G;
  localparam int T_DONE = R + P + 4 * SLOT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic phy_resetn, mdio_scl, mdio_sda, phy_init_done;
  phy_mdio_init_sequencer #(
    .CLK_DIV(D), .RESET_CYCLES(R), .POST_RESET_CYCLES(P), .PHY_ADDR(5'd1), .GAP_CYCLES(G)
  ) dut (
    .clock(clk),
    .reset(rst),
    .phy_resetn(phy_resetn),
    .mdio_scl(mdio_scl),
    .mdio_sda(mdio_sda),
    .phy_init_done(phy_init_done)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int t = 0;
  bit chk = 1'b0;
  logic [4:0] regs [4] = '{5'h00, 5'h04, 5'h09, 5'h00};
  logic [15:0] datas [4] = '{16'h8000, 16'h01E1, 16'h0200, 16'h1340};
  logic [63:0] lit_frames [4] = '{64'hFFFFFFFF_50828000, 64'hFFFFFFFF_509201E1,
                                  64'hFFFFFFFF_50A60200, 64'hFFFFFFFF_50821340};
  logic [63:0] frames [$];
  int edges = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask
  function automatic logic [63:0] frame_of(input int i);
    return {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, regs[i], 2'b10, datas[i]};
  endfunction
  // Expected {phy_resetn, mdio_scl, mdio_sda, phy_init_done} t cycles after the last reset-high edge.
  function automatic logic [3:0] model(input int tt);
    logic rn, scl, sda, dn;
    logic [63:0] f;
    int s, o;
    rn = tt >= R;
    dn = tt >= T_DONE;
    scl = 1'b0;
    sda = 1'b1;
    if (tt >= R + P && !dn) begin
      s = tt - R - P;
      o = s % SLOT;
      if (o < FT) begin
        f = frame_of(s / SLOT);
        scl = (o % (2 * D)) >= D;
        sda = f[63 - o / (2 * D)];
      end
    end
    return {rn, scl, sda, dn};
  endfunction
  always @(posedge clk) begin
    t <= rst ? 0 : t + 1;
    if (rst) chk <= 1'b1;
  end
  always @(negedge clk) begin
    logic [3:0] e;
    if (chk) begin
      e = model(t);
      check("model_phy_resetn", phy_resetn, e[3]);
      check("model_mdio_scl", mdio_scl, e[2]);
      check("model_mdio_sda", mdio_sda, e[1]);
      check("model_phy_init_done", phy_init_done, e[0]);
    end
  end
  logic prev_scl = 1'b0;
  logic prev_sda = 1'b1;
  logic [63:0] sr = '0;
  int bitcnt = 0;
  int last_rise = 0;
  always @(negedge clk) begin
    if (chk) begin
      if (t == 0) begin
        bitcnt = 0;
      end else begin
        if (!prev_scl && mdio_scl) begin
          if (bitcnt > 0) check("mdc_period", t - last_rise, 2 * D);
          last_rise = t;
          sr = {sr[62:0], mdio_sda};
          bitcnt++;
          edges++;
          if (bitcnt == 64) begin
            frames.push_back(sr);
            bitcnt = 0;
          end
        end
        if (prev_scl && mdio_scl) check("sda_stable_while_mdc_high", mdio_sda, prev_sda);
      end
      prev_scl = mdio_scl;
      prev_sda = mdio_sda;
    end
  end
  task automatic check_reset_values(input string tag);
    check({tag, "_phy_resetn"}, phy_resetn, 1'b0);
    check({tag, "_mdio_scl"}, mdio_scl, 1'b0);
    check({tag, "_mdio_sda"}, mdio_sda, 1'b1);
    check({tag, "_phy_init_done"}, phy_init_done, 1'b0);
  endtask
  task automatic wait_done_and_check();
    int k;
    k = 0;
    while (!phy_init_done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", phy_init_done, 1'b1);
    check("done_cycle", t, 1070);
    check("frame_count", frames.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < frames.size()) begin
        check($sformatf("frame%0d_bits", i), frames[i], lit_frames[i]);
        check($sformatf("frame%0d_reg", i), frames[i][22:18], regs[i]);
        check($sformatf("frame%0d_data", i), frames[i][15:0], datas[i]);
      end
    end
    check("mdc_rising_edges", edges, 256);
  endtask
  initial begin
    int n, k, e0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    n = 0;
    while (!phy_resetn && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("phy_resetn_low_cycles", n, R);
    wait_done_and_check();
    e0 = edges;
    repeat (1000) @(negedge clk);
    check("done_sticky", phy_init_done, 1'b1);
    check("no_mdc_after_done", edges, e0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frames.delete();
    edges = 0;
    k = 0;
    while (t != 712 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("reached_frame2_bit40", t, 712);
    check("frames_before_abort", frames.size(), 2);
    check("mdc_high_at_abort", mdio_scl, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("abort");
    rst = 1'b0;
    frames.delete();
    edges = 0;
    wait_done_and_check();
    rst = 1'b1;
    e0 = edges;
    repeat (50) begin
      @(negedge clk);
      check_reset_values("hold");
    end
    check("no_mdc_in_reset", edges, e0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/phy_mdio_init_sequencer.md
Name: phy_mdio_init_sequencer

Overview:
Bring-up sequencer for the external RGMII Ethernet PHY, running in the 125 MHz clk_125 domain. After reset it pulses the PHY hardware reset, waits for the PHY to settle, then bit-bangs a fixed list of Clause-22 MDIO write frames on an output-only MDC/MDIO pair. It then raises phy_init_done, which gates the Ethernet MAC core out of reset.

Parameters:
CLK_DIV, 32, clock cycles per MDC half-period (MDC = 125 MHz / 64 ≈ 1.95 MHz); must be ≥1.
RESET_CYCLES, 1250000, cycles phy_resetn is held low (10 ms).
POST_RESET_CYCLES, 6250000, cycles waited after phy_resetn rises before the first frame (50 ms).
PHY_ADDR, 5'd1, 5-bit PHY address placed in every frame.
GAP_CYCLES, 64, idle cycles between consecutive frames.

Ports:
clock  in  1  system clock (clk_125); all logic on its rising edge.
reset  in  1  synchronous, active-high; restarts the whole sequence.
phy_resetn  out  1  PHY hardware reset, active-low.
mdio_scl  out  1  MDC.
mdio_sda  out  1  MDIO data, always driven; no readback.
phy_init_done  out  1  high once all writes are complete; sticky until reset.

Behaviour:
- Reset values, in the cycle after reset is sampled high: phy_resetn=0, mdio_scl=0, mdio_sda=1, phy_init_done=0, state=HOLD, all counters 0. Reset mid-frame aborts the frame and restarts from HOLD.
- All outputs are registered; there is no combinational path from input to output.
- HOLD: phy_resetn=0 for RESET_CYCLES cycles, then phy_resetn=1 and go to SETTLE.
- SETTLE: wait POST_RESET_CYCLES, then go to FRAME with entry index 0.
- FRAME: shift 64 bits MSB-first:
  - 32 × '1' preamble, ST=01, OP=01 (write), PHY_ADDR[4:0], REG[4:0], TA=10, DATA[15:0].
- Bit timing: each bit occupies 2*CLK_DIV cycles.
  - First half: mdio_scl=0, with mdio_sda updated to the bit in the first cycle of the half.
  - Second half: mdio_scl=1; the PHY samples on this rising edge.
  - mdio_sda holds stable for the whole bit.
- After bit 63: mdio_scl=0, mdio_sda=1, go to GAP.
- GAP: GAP_CYCLES idle with mdio_scl=0 and mdio_sda=1. Then, if the index is NUM_WRITES-1, go to DONE; otherwise increment the index and go to FRAME.
- DONE: phy_init_done=1, phy_resetn=1, mdio_scl=0, mdio_sda=1; stays there until reset.
- Write table (constant ROM, index → {reg, data}):
  - 0 → {5'h00, 16'h8000}: soft reset.
  - 1 → {5'h04, 16'h01E1}: advertise 10/100.
  - 2 → {5'h09, 16'h0200}: advertise 1000FD.
  - 3 → {5'h00, 16'h1340}: autoneg enable + restart.
  - NUM_WRITES=4.
- Counter widths are sized by $clog2 of the largest parameter. Counters do not wrap, because every terminal count is compared exactly.
- Total frame time is 64*2*CLK_DIV cycles. phy_init_done rises exactly RESET_CYCLES + POST_RESET_CYCLES + NUM_WRITES*(128*CLK_DIV + GAP_CYCLES) cycles after reset deasserts, ±1 cycle for state entry, constant per implementation.

Decomposition:
- Package phy_init_pkg holds:
  - state enum {HOLD, SETTLE, FRAME, GAP, DONE};
  - MDIO constants: ST=2'b01, OP_WRITE=2'b01, TA=2'b10, PREAMBLE_BITS=32, FRAME_BITS=64;
  - NUM_WRITES and the write-table constant array.
- One sub-module is natural: mdio_write_shifter. It takes start, a 64-bit frame and CLK_DIV, and produces mdc, mdio and busy/done. The top-level FSM sequences table entries into it.

Test Plan:
- Reset release (RESET_CYCLES=10, POST_RESET_CYCLES=20, CLK_DIV=2, GAP_CYCLES=4) -> phy_resetn=0 for exactly 10 cycles, then 1; mdio_scl=0 and mdio_sda=1 throughout HOLD and SETTLE.
- Frame 0 decode, sampling mdio_sda on each mdio_scl rising edge -> 32 ones, then 01 01 00001 00000 10 1000000000000000; exactly 64 MDC rising edges.
- MDC timing with CLK_DIV=2 -> mdio_scl period 4 cycles, 50% duty; mdio_sda never changes while mdio_scl=1.
- Full sequence -> 4 frames decode to reg/data 00/8000, 04/01E1, 09/0200, 00/1340. Then phy_init_done=1 at the predicted cycle and stays 1 for 1000 further cycles with no more MDC edges.
- Reset asserted mid-frame 2 (bit 40) -> the next cycle shows phy_resetn=0, mdio_scl=0, mdio_sda=1, phy_init_done=0. The sequence then restarts from HOLD and completes all 4 frames.
- Reset held high for 50 cycles -> outputs stay at reset values, with no MDC edges.
